// File: rtl/mips_alu.sv
// Registered 32-bit MIPS execute-stage ALU: thirteen opcodes, result plus
// zero/carry/negative flags, all valid one clock after the operands are sampled.
`timescale 1ns/1ps

module mips_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             negative
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOR  = 4'b0101,
        OP_SLT  = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_MULT = 4'b1011,
        OP_LUI  = 4'b1100
    } op_e;

    logic [WIDTH:0]          add_full;
    logic [WIDTH:0]          sub_full;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH:0]          prod_hi;
    logic                    mult_ovf;
    logic signed [WIDTH-1:0] a_s;
    logic [SHW-1:0]          shamt;

    logic [WIDTH-1:0] out_d, out_q;
    logic             zero_d, zero_q;
    logic             carry_d, carry_q;
    logic             negative_d, negative_q;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};
    assign a_s      = $signed(a);
    assign shamt    = b[SHW-1:0];

    // Operands are sign-extended to full product width so the 2W-bit multiply is exact.
    assign prod     = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_hi  = prod[2*WIDTH-1:WIDTH-1];
    assign mult_ovf = !((&prod_hi) || !(|prod_hi));

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can be inferred.
        out_d   = '0;
        carry_d = 1'b0;
        case (opt)
            OP_ADD:  begin out_d = add_full[WIDTH-1:0]; carry_d = add_full[WIDTH]; end
            OP_SUB:  begin out_d = sub_full[WIDTH-1:0]; carry_d = sub_full[WIDTH]; end
            OP_AND:  out_d = a & b;
            OP_OR:   out_d = a | b;
            OP_XOR:  out_d = a ^ b;
            OP_NOR:  out_d = ~(a | b);
            OP_SLT:  out_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: out_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  out_d = a << shamt;
            OP_SRL:  out_d = a >> shamt;
            OP_SRA:  out_d = a_s >>> shamt;
            OP_MULT: begin out_d = prod[WIDTH-1:0]; carry_d = mult_ovf; end
            OP_LUI:  out_d = {b[15:0], {(WIDTH-16){1'b0}}};
            default: begin out_d = '0; carry_d = 1'b0; end
        endcase
        zero_d     = (out_d == '0);
        negative_d = out_d[WIDTH-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q      <= '0;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            out_q      <= out_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            negative_q <= negative_d;
        end
    end

    assign out      = out_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign negative = negative_q;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed spec cases per feature plus
// randomized back-to-back traffic against an arithmetic reference model.
`timescale 1ns/1ps

module tb_mips_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opt;
    logic [31:0] a, b;
    logic [31:0] out;
    logic        zero, carry, negative;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        z;
        logic        c;
        logic        n;
    } vec_t;

    mips_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opt(opt), .a(a), .b(b),
        .out(out), .zero(zero), .carry(carry), .negative(negative)
    );

    always #5 clk = ~clk;

    function automatic string show(input logic [34:0] x);
        return $sformatf("out=%h z=%b c=%b n=%b", x[34:3], x[2], x[1], x[0]);
    endfunction

    // Reference model: the opcode rules written with plain signed/unsigned integer arithmetic.
    function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      ux = x;
        longint      uy = y;
        int          sx = x;
        int          sy = y;
        longint      s, p;
        longint      lim = 64'sh7FFFFFFF;
        logic [31:0] r = 32'd0;
        logic        c = 1'b0;
        case (op)
            4'd0:  begin s = ux + uy; r = s[31:0]; c = s[32]; end
            4'd1:  begin r = x - y; c = (ux < uy); end
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = ~(x | y);
            4'd6:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd7:  r = (ux < uy) ? 32'd1 : 32'd0;
            4'd8:  r = x << y[4:0];
            4'd9:  r = x >> y[4:0];
            4'd10: begin s = sx >>> y[4:0]; r = s[31:0]; end
            4'd11: begin p = longint'(sx) * longint'(sy); r = p[31:0]; c = (p > lim) || (p < -lim - 1); end
            4'd12: r = {y[15:0], 16'h0000};
            default: begin r = 32'd0; c = 1'b0; end
        endcase
        return {r, (r == 32'd0), c, r[31]};
    endfunction

    task automatic step(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        opt = op;
        a   = x;
        b   = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({out, zero, carry, negative} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_async: got %s, want %s", show({out, zero, carry, negative}), show({32'd0, 3'b100}));
        end
        opt = 4'd0; a = 32'd5; b = 32'd6;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out, zero, carry, negative} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_held_over_edge: got %s, want %s", show({out, zero, carry, negative}), show({32'd0, 3'b100}));
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arith();
        vec_t v[6];
        v[0] = '{"add_basic",    4'd0,  32'd1234,     32'd4321,     32'd5555,     1'b0, 1'b0, 1'b0};
        v[1] = '{"add_wrap",     4'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1, 1'b0};
        v[2] = '{"sub_borrow",   4'd1,  32'd1234,     32'd4321,     32'hFFFFF3F1, 1'b0, 1'b1, 1'b1};
        v[3] = '{"sub_boundary", 4'd1,  32'h80000001, 32'd2,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b0};
        v[4] = '{"mult_neg",     4'd11, 32'd12,       32'hFFFFFFDE, 32'hFFFFFE68, 1'b0, 1'b0, 1'b1};
        v[5] = '{"mult_ovf",     4'd11, 32'h00010000, 32'h00010000, 32'd0,        1'b1, 1'b1, 1'b0};
        foreach (v[i]) begin
            step(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if ({out, zero, carry, negative} !== {v[i].out, v[i].z, v[i].c, v[i].n}) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", v[i].name, show({out, zero, carry, negative}),
                         show({v[i].out, v[i].z, v[i].c, v[i].n}));
            end
        end
    endtask

    task automatic test_logic_shift_compare();
        vec_t v[11];
        v[0]  = '{"and",        4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b1};
        v[1]  = '{"or",         4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b1};
        v[2]  = '{"xor",        4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        v[3]  = '{"nor",        4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0};
        v[4]  = '{"sra_sign",   4'd10, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b1};
        v[5]  = '{"srl_zero",   4'd9,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 1'b0};
        v[6]  = '{"slt_signed", 4'd6,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
        v[7]  = '{"sltu",       4'd7,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0};
        v[8]  = '{"sll_hi_ign", 4'd8,  32'd1,        32'hFFFFFFE1, 32'd2,        1'b0, 1'b0, 1'b0};
        v[9]  = '{"lui",        4'd12, 32'h55555555, 32'h1234ABCD, 32'hABCD0000, 1'b0, 1'b0, 1'b1};
        v[10] = '{"slt_false",  4'd6,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
        foreach (v[i]) begin
            step(v[i].op, v[i].a, v[i].b);
            n_cmp++;
            if ({out, zero, carry, negative} !== {v[i].out, v[i].z, v[i].c, v[i].n}) begin
                n_err++;
                $display("FAIL %s: got %s, want %s", v[i].name, show({out, zero, carry, negative}),
                         show({v[i].out, v[i].z, v[i].c, v[i].n}));
            end
        end
    endtask

    task automatic test_undefined();
        for (int op = 13; op <= 15; op++) begin
            step(4'(op), 32'hFFFFFFFF, 32'hFFFFFFFF);
            n_cmp++;
            if ({out, zero, carry, negative} !== {32'd0, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL undefined_op%0d: got %s, want %s", op, show({out, zero, carry, negative}), show({32'd0, 3'b100}));
            end
        end
    endtask

    task automatic test_latency();
        step(4'd0, 32'd100, 32'd23);
        #1;
        opt = 4'd1; a = 32'd5; b = 32'd9;
        #1;
        n_cmp++;
        if ({out, zero, carry, negative} !== {32'd123, 3'b000}) begin
            n_err++;
            $display("FAIL latency_hold: got %s, want %s", show({out, zero, carry, negative}), show({32'd123, 3'b000}));
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out, zero, carry, negative} !== {32'hFFFFFFFC, 3'b011}) begin
            n_err++;
            $display("FAIL latency_update: got %s, want %s", show({out, zero, carry, negative}), show({32'hFFFFFFFC, 3'b011}));
        end
    endtask

    task automatic test_reset_mid();
        step(4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out, zero, carry, negative} !== {32'd0, 3'b100}) begin
            n_err++;
            $display("FAIL reset_mid: got %s, want %s", show({out, zero, carry, negative}), show({32'd0, 3'b100}));
        end
        @(negedge clk);
        reset = 1'b0;
        step(4'd0, 32'd1, 32'd1);
        n_cmp++;
        if ({out, zero, carry, negative} !== {32'd2, 3'b000}) begin
            n_err++;
            $display("FAIL reset_recover: got %s, want %s", show({out, zero, carry, negative}), show({32'd2, 3'b000}));
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  op;
        logic [31:0] x, y;
        logic [34:0] exp;
        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 5))
                0: x = 32'h80000000 ^ 32'($urandom_range(0, 3));
                1: y = 32'($urandom_range(0, 40));
                2: y = x;
                3: begin x = 32'($signed(16'($urandom))); y = 32'($signed(16'($urandom))); end
                default: ;
            endcase
            exp = model(op, x, y);
            step(op, x, y);
            n_cmp++;
            if ({out, zero, carry, negative} !== exp) begin
                n_err++;
                $display("FAIL random op=%0d a=%h b=%h: got %s, want %s", op, x, y,
                         show({out, zero, carry, negative}), show(exp));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        opt   = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        #2;
        test_reset();
        test_arith();
        test_logic_shift_compare();
        test_undefined();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
